serial_twos_comp_n: RTL and testbench

//  Parametrised bit-serial Mealy complementer. Latches a WIDTH-bit operand, streams it LSB-first

---
 rtl/serial_twos_comp_n.sv | 129 ++++++++++++
 tb/tb_serial_twos_comp_n.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/serial_twos_comp_n.sv
// Bit-serial Mealy complementer: latches a WIDTH-bit operand and streams it LSB-first,
// producing pass, two's-complement, absolute value or one's-complement results.
module serial_twos_comp_n #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] din,
  output logic             busy,
  output logic             done,
  output logic             sout,
  output logic             sout_valid,
  output logic [WIDTH-1:0] result,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] MODE_PASS = 2'b00;
  localparam logic [1:0] MODE_NEG  = 2'b01;
  localparam logic [1:0] MODE_ABS  = 2'b10;
  localparam logic [1:0] MODE_INV  = 2'b11;

  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CW-1:0]    LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] r_result;
  logic [CW-1:0]    r_cnt;
  logic [1:0]       r_mode;
  logic             r_neg;
  logic             r_flag;
  logic             r_ovf_pend;
  logic             r_ovf;
  logic             r_busy;
  logic             r_done;

  logic             w_sout;
  logic             w_accept;
  logic             w_neg_next;
  logic [WIDTH-1:0] w_sr_next;

  // The flag records whether a 1 has already passed; once set, a negating
  // operation inverts every remaining bit (copy-through-first-one rule).
  always_comb begin
    w_sout = 1'b0;
    if (r_state == S_SHIFT) begin
      if (r_mode == MODE_INV) w_sout = ~r_sr[0];
      else                    w_sout = r_sr[0] ^ (r_neg & r_flag);
    end
  end

  assign w_accept   = start && (r_state != S_SHIFT);
  assign w_neg_next = (mode == MODE_NEG) || ((mode == MODE_ABS) && din[WIDTH-1]);
  assign w_sr_next  = {w_sout, r_sr[WIDTH-1:1]};

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would let later statements see updated values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_sr       <= '0;
      r_result   <= '0;
      r_cnt      <= '0;
      r_mode     <= MODE_PASS;
      r_neg      <= 1'b0;
      r_flag     <= 1'b0;
      r_ovf_pend <= 1'b0;
      r_ovf      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          if (w_accept) begin
            r_state    <= S_SHIFT;
            r_busy     <= 1'b1;
            r_sr       <= din;
            r_mode     <= mode;
            r_neg      <= w_neg_next;
            r_flag     <= 1'b0;
            r_cnt      <= '0;
            r_ovf_pend <= ((mode == MODE_NEG) || (mode == MODE_ABS)) && (din == MIN_VAL);
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end

        S_SHIFT: begin
          r_flag <= r_flag | r_sr[0];
          r_sr   <= w_sr_next;
          r_cnt  <= r_cnt + 1'b1;
          if (r_cnt == LAST_CNT) begin
            r_result <= w_sr_next;
            r_ovf    <= r_ovf_pend;
            r_state  <= S_DONE;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign sout       = w_sout;
  assign sout_valid = r_busy;
  assign result     = r_result;
  assign ovf        = r_ovf;

endmodule

// File: tb/tb_serial_twos_comp_n.sv
// Self-checking bench for serial_twos_comp_n (WIDTH=8): directed table, corner
// sequences and randomized operations against an arithmetic reference model.
module tb_serial_twos_comp_n;

  localparam int W = 8;
  localparam logic [1:0] PASS = 2'b00;
  localparam logic [1:0] NEG  = 2'b01;
  localparam logic [1:0] ABS  = 2'b10;
  localparam logic [1:0] INV  = 2'b11;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [1:0]   mode;
  logic [W-1:0] din;
  logic         busy, done, sout, sout_valid, ovf;
  logic [W-1:0] result;

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] last_res;
  logic         last_ovf;

  typedef struct {
    logic [1:0]   mode;
    logic [W-1:0] din;
    logic [W-1:0] exp_res;
    logic         exp_ovf;
  } vec_t;

  vec_t vecs[11];

  serial_twos_comp_n #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .mode       (mode),
    .din        (din),
    .busy       (busy),
    .done       (done),
    .sout       (sout),
    .sout_valid (sout_valid),
    .result     (result),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: modulo-256 integer arithmetic on the operand value.
  function automatic logic [W:0] model(input logic [1:0] m, input logic [W-1:0] d);
    int v, r;
    logic o;
    v = int'(d);
    case (m)
      PASS:    r = v;
      NEG:     r = (256 - v) % 256;
      ABS:     r = (v >= 128) ? (256 - v) % 256 : v;
      default: r = 255 - v;
    endcase
    o = ((m == NEG) || (m == ABS)) && (v == 128);
    return {o, r[W-1:0]};
  endfunction

  task automatic run_op(input logic [1:0] m, input logic [W-1:0] d,
                        input logic [W-1:0] er, input logic eo, input string tag);
    @(negedge clk);
    start = 1'b1; mode = m; din = d;
    step();
    start = 1'b0; mode = 2'($urandom); din = W'($urandom);
    for (int i = 0; i < W; i++) begin
      check($sformatf("%s valid[%0d]", tag, i), {busy, sout_valid}, 2'b11);
      check($sformatf("%s sout[%0d]", tag, i), sout, er[i]);
      check($sformatf("%s early_done[%0d]", tag, i), done, 1'b0);
      if (i == 4) check($sformatf("%s result_hold", tag), {ovf, result}, {last_ovf, last_res});
      step();
    end
    check({tag, " done"}, {done, busy}, 2'b10);
    check({tag, " result"}, result, er);
    check({tag, " ovf"}, ovf, eo);
    last_res = er;
    last_ovf = eo;
    step();
    check({tag, " done_pulse"}, done, 1'b0);
  endtask

  initial begin
    logic [W:0] ref_v;
    logic [W-1:0] rd;
    logic [1:0] rm;
    logic [W-1:0] ff_v;
    int done_seen;

    vecs[0]  = '{NEG,  8'h05, 8'hFB, 1'b0};
    vecs[1]  = '{ABS,  8'hF6, 8'h0A, 1'b0};
    vecs[2]  = '{ABS,  8'h0A, 8'h0A, 1'b0};
    vecs[3]  = '{INV,  8'h3C, 8'hC3, 1'b0};
    vecs[4]  = '{PASS, 8'h5A, 8'h5A, 1'b0};
    vecs[5]  = '{NEG,  8'h80, 8'h80, 1'b1};
    vecs[6]  = '{NEG,  8'h00, 8'h00, 1'b0};
    vecs[7]  = '{ABS,  8'h80, 8'h80, 1'b1};
    vecs[8]  = '{PASS, 8'h80, 8'h80, 1'b0};
    vecs[9]  = '{INV,  8'h80, 8'h7F, 1'b0};
    vecs[10] = '{NEG,  8'h01, 8'hFF, 1'b0};

    rst_n = 1'b0; start = 1'b0; mode = PASS; din = '0;
    step(); step();
    rst_n = 1'b1;
    step();
    check("reset busy/done/ovf", {busy, done, ovf}, 3'b000);
    check("reset result", result, 8'h00);
    check("reset sout_valid", sout_valid, 1'b0);
    last_res = '0;
    last_ovf = 1'b0;

    for (int i = 0; i < 11; i++)
      run_op(vecs[i].mode, vecs[i].din, vecs[i].exp_res, vecs[i].exp_ovf, $sformatf("vec%0d", i));

    // Start pulsed mid-SHIFT is ignored; start held through DONE re-accepts.
    @(negedge clk);
    start = 1'b1; mode = NEG; din = 8'h05;
    step();
    start = 1'b0;
    step(); step(); step();
    start = 1'b1; mode = INV; din = 8'h11;
    step();
    start = 1'b0;
    check("ignore busy", busy, 1'b1);
    step(); step(); step();
    start = 1'b1; mode = NEG; din = 8'h01;
    step();
    check("ignore done", {done, busy}, 2'b10);
    check("ignore result", result, 8'hFB);
    check("ignore ovf", ovf, 1'b0);
    step();
    start = 1'b0;
    check("reaccept busy", {busy, done}, 2'b10);
    ff_v = 8'hFF;
    for (int i = 0; i < W; i++) begin
      check($sformatf("reaccept sout[%0d]", i), sout, ff_v[i]);
      step();
    end
    check("reaccept done", done, 1'b1);
    check("reaccept result", result, 8'hFF);
    last_res = 8'hFF;
    last_ovf = 1'b0;
    step();

    // Reset mid-SHIFT discards the operation.
    @(negedge clk);
    start = 1'b1; mode = NEG; din = 8'h05;
    step();
    start = 1'b0;
    step(); step(); step(); step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("midreset state", {busy, done, ovf, sout_valid}, 4'b0000);
    check("midreset result", result, 8'h00);
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) done_seen++;
      step();
    end
    check("midreset no done", done_seen, 0);
    last_res = '0;
    last_ovf = 1'b0;
    run_op(NEG, 8'h05, 8'hFB, 1'b0, "post_reset");

    for (int i = 0; i < 40; i++) begin
      rm = 2'($urandom);
      case ($urandom_range(0, 7))
        0:       rd = 8'h80;
        1:       rd = 8'h00;
        default: rd = W'($urandom);
      endcase
      ref_v = model(rm, rd);
      run_op(rm, rd, ref_v[W-1:0], ref_v[W], $sformatf("rand%0d m%0d d%02h", i, rm, rd));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
